hdmi_rx_i2c_reg_xfer: RTL and testbench

- Register-transaction engine between the HDMI receiver control sequencer and the I2C byte controller.
- Accepts one register read or write request (device address byte, register index, write data).
- Expands it into the START/WRITE/READ/STOP byte-command sequence, handles NACK retry, arbitration loss and timeout, and returns read data and a status code.
- Lets the control sequencer issue whole register accesses instead of hand-stepping byte commands.

---
 rtl/hdmi_rx_i2c_reg_xfer.sv | 170 +++++++++++++++++
 tb/tb_hdmi_rx_i2c_reg_xfer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_rx_i2c_reg_xfer.sv
// Register-transaction engine: expands one register read/write request into the
// I2C byte-controller command sequence, with NACK retry, arbitration-loss and timeout handling.
module hdmi_rx_i2c_reg_xfer #(
   parameter int MAX_RETRY   = 2,
   parameter int TIMEOUT_CYC = 65535,
   parameter int GAP_CYC     = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_rw,
   input  logic [7:0] req_dev,
   input  logic [7:0] req_reg,
   input  logic [7:0] req_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic [1:0] rsp_err,
   output logic       i2c_start,
   output logic       i2c_stop,
   output logic       i2c_read,
   output logic       i2c_write,
   output logic       i2c_ack_out,
   output logic [7:0] i2c_din,
   input  logic       i2c_cmd_ack,
   input  logic       i2c_ack_in,
   input  logic [7:0] i2c_dout,
   input  logic       i2c_al
);

   typedef enum logic [3:0] {
      S_IDLE, S_DEV, S_REG, S_RDEV, S_RD, S_DATA, S_STOPONLY, S_GAP, S_DONE
   } state_t;

   localparam logic [1:0]  ERR_OK    = 2'd0;
   localparam logic [1:0]  ERR_NACK  = 2'd1;
   localparam logic [1:0]  ERR_AL    = 2'd2;
   localparam logic [1:0]  ERR_TO    = 2'd3;
   localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CYC - 1);
   localparam logic [15:0] GAP_LAST  = 16'(GAP_CYC - 1);
   localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);

   state_t      state, state_nxt, ret, ret_nxt;
   logic [15:0] cnt;
   logic [7:0]  retry_cnt;
   logic        rw_q;
   logic [7:0]  dev_q, reg_q, wdata_q;
   logic        accept, cmd_phase, timed_out, retry_inc;
   logic [1:0]  fin_err;
   logic [7:0]  fin_rdata;

   assign accept    = req_valid && req_ready;
   assign cmd_phase = state inside {S_DEV, S_REG, S_RDEV, S_RD, S_DATA, S_STOPONLY};
   assign timed_out = cmd_phase && !i2c_cmd_ack && (cnt == TO_LAST);
   assign rsp_valid = (state == S_DONE);

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      ret_nxt   = ret;
      retry_inc = 1'b0;
      fin_err   = ERR_OK;
      fin_rdata = 8'h00;
      if (state == S_IDLE) begin
         if (accept) state_nxt = S_DEV;
      end else if (state == S_DONE) begin
         state_nxt = S_IDLE;
      end else if (i2c_al) begin
         // Arbitration loss wins over a coincident cmd_ack; the bus is no longer ours.
         state_nxt = S_DONE;
         fin_err   = ERR_AL;
      end else if (timed_out) begin
         state_nxt = S_DONE;
         fin_err   = ERR_TO;
      end else begin
         case (state)
            S_GAP: if (cnt == GAP_LAST) state_nxt = ret;
            S_DEV, S_REG, S_RDEV: begin
               if (i2c_cmd_ack) begin
                  state_nxt = S_GAP;
                  if (i2c_ack_in)            ret_nxt = S_STOPONLY;
                  else if (state == S_DEV)   ret_nxt = S_REG;
                  else if (state == S_RDEV)  ret_nxt = S_RD;
                  else                       ret_nxt = rw_q ? S_RDEV : S_DATA;
               end
            end
            S_RD: begin
               if (i2c_cmd_ack) begin
                  state_nxt = S_DONE;
                  fin_rdata = i2c_dout;
               end
            end
            S_DATA, S_STOPONLY: begin
               // The bus is released here, so a NACK leads straight to retry-or-fail.
               if (i2c_cmd_ack && (state == S_STOPONLY || i2c_ack_in)) begin
                  if (retry_cnt < RETRY_MAX) begin
                     retry_inc = 1'b1;
                     state_nxt = S_GAP;
                     ret_nxt   = S_DEV;
                  end else begin
                     state_nxt = S_DONE;
                     fin_err   = ERR_NACK;
                  end
               end else if (i2c_cmd_ack) begin
                  state_nxt = S_DONE;
               end
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      i2c_start   = 1'b0;
      i2c_stop    = 1'b0;
      i2c_read    = 1'b0;
      i2c_write   = 1'b0;
      i2c_ack_out = 1'b0;
      i2c_din     = 8'h00;
      if (!i2c_al) begin
         case (state)
            S_DEV:      begin i2c_start = 1'b1; i2c_write = 1'b1; i2c_din = dev_q & 8'hFE; end
            S_REG:      begin i2c_write = 1'b1; i2c_din = reg_q; end
            S_RDEV:     begin i2c_start = 1'b1; i2c_write = 1'b1; i2c_din = dev_q | 8'h01; end
            S_DATA:     begin i2c_write = 1'b1; i2c_stop = 1'b1; i2c_din = wdata_q; end
            S_RD:       begin i2c_read = 1'b1; i2c_stop = 1'b1; i2c_ack_out = 1'b1; end
            S_STOPONLY: i2c_stop = 1'b1;
            default:    ;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         ret       <= S_IDLE;
         cnt       <= 16'd0;
         retry_cnt <= 8'd0;
         req_ready <= 1'b0;
         rsp_err   <= ERR_OK;
         rsp_rdata <= 8'h00;
         rw_q      <= 1'b0;
         dev_q     <= 8'h00;
         reg_q     <= 8'h00;
         wdata_q   <= 8'h00;
      end else begin
         state     <= state_nxt;
         ret       <= ret_nxt;
         req_ready <= (state_nxt == S_IDLE);
         // Counter restarts on every state change: it is the per-step timeout and the gap timer.
         if (state_nxt != state || !(cmd_phase || state == S_GAP)) cnt <= 16'd0;
         else                                                     cnt <= cnt + 16'd1;
         if (accept) begin
            rw_q      <= req_rw;
            dev_q     <= req_dev;
            reg_q     <= req_reg;
            wdata_q   <= req_wdata;
            retry_cnt <= 8'd0;
         end else if (retry_inc) begin
            retry_cnt <= retry_cnt + 8'd1;
         end
         if (state_nxt == S_DONE && state != S_DONE) begin
            rsp_err   <= fin_err;
            rsp_rdata <= fin_rdata;
         end
      end
   end

endmodule

// File: tb/tb_hdmi_rx_i2c_reg_xfer.sv
// Directed bench for hdmi_rx_i2c_reg_xfer: a behavioural I2C byte-controller model
// logs every command; a vector table plus hand sequences check responses and command streams.
module tb_hdmi_rx_i2c_reg_xfer;

   localparam int GAP_CYC = 4;
   localparam int TO_CYC  = 100;
   localparam int ACK_DLY = 2;

   // Command bit encoding {start, stop, read, write, ack_out}
   localparam logic [4:0] B_DEV  = 5'b10010;
   localparam logic [4:0] B_REG  = 5'b00010;
   localparam logic [4:0] B_DATA = 5'b01010;
   localparam logic [4:0] B_RD   = 5'b01101;
   localparam logic [4:0] B_STOP = 5'b01000;

   logic       clk = 1'b0;
   logic       reset;
   logic       req_valid, req_ready, req_rw;
   logic [7:0] req_dev, req_reg, req_wdata;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic [1:0] rsp_err;
   logic       i2c_start, i2c_stop, i2c_read, i2c_write, i2c_ack_out;
   logic [7:0] i2c_din;
   logic       i2c_cmd_ack, i2c_ack_in, i2c_al;
   logic [7:0] i2c_dout;

   hdmi_rx_i2c_reg_xfer #(.MAX_RETRY(2), .TIMEOUT_CYC(TO_CYC), .GAP_CYC(GAP_CYC)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
      .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .i2c_start(i2c_start), .i2c_stop(i2c_stop), .i2c_read(i2c_read),
      .i2c_write(i2c_write), .i2c_ack_out(i2c_ack_out), .i2c_din(i2c_din),
      .i2c_cmd_ack(i2c_cmd_ack), .i2c_ack_in(i2c_ack_in),
      .i2c_dout(i2c_dout), .i2c_al(i2c_al)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct packed {
      logic [4:0] bits;
      logic [7:0] din;
   } cmd_t;

   // Byte-controller model state and transaction log
   cmd_t cmd_log[$];
   cmd_t held;
   int   age = 0, idle_cnt = 0, min_gap, stab_err, last_active, dev_seen, al_drop_bad;
   logic prev_active = 1'b0;
   int   nack_dev = 0, al_idx = -1;
   bit   no_ack = 1'b0;

   task automatic clear_model();
      cmd_log.delete();
      min_gap     = 1000;
      stab_err    = 0;
      last_active = 0;
      dev_seen    = 0;
      al_drop_bad = 0;
   endtask

   initial begin
      cmd_t cur;
      logic act;
      i2c_cmd_ack = 1'b0;
      i2c_ack_in  = 1'b0;
      i2c_al      = 1'b0;
      i2c_dout    = 8'hA5;
      forever begin
         @(negedge clk);
         cur = '{bits: {i2c_start, i2c_stop, i2c_read, i2c_write, i2c_ack_out}, din: i2c_din};
         act = i2c_start | i2c_stop | i2c_read | i2c_write;
         i2c_cmd_ack = 1'b0;
         i2c_ack_in  = 1'b0;
         i2c_al      = 1'b0;
         if (act) begin
            if (!prev_active) begin
               if (cmd_log.size() > 0 && idle_cnt < min_gap) min_gap = idle_cnt;
               cmd_log.push_back(cur);
               held = cur;
               age  = 0;
               if (cur.bits[4] && cur.bits[1] && !cur.din[0]) dev_seen++;
            end else if (cur != held) begin
               stab_err++;
            end
            age++;
            last_active = age;
            idle_cnt    = 0;
            if (!no_ack && age == ACK_DLY) begin
               i2c_cmd_ack = 1'b1;
               i2c_ack_in  = cur.bits[4] && cur.bits[1] && !cur.din[0] && (dev_seen <= nack_dev);
               if (int'(cmd_log.size()) - 1 == al_idx) begin
                  i2c_al = 1'b1;
                  #1;
                  if (i2c_start | i2c_stop | i2c_read | i2c_write) al_drop_bad++;
               end
            end
         end else begin
            idle_cnt++;
         end
         prev_active = act;
      end
   end

   typedef struct {
      logic            rw;
      logic [7:0]      dev, rg, wdata;
      int              nack_dev, al_idx;
      bit              no_ack;
      logic [1:0]      exp_err;
      logic [7:0]      exp_rdata;
      int              exp_ncmd, exp_nstop, exp_active;
      logic [3:0][4:0] exp_bits;   // [3] is the first command
      logic [3:0][7:0] exp_din;
   } vec_t;

   function automatic vec_t mkv(logic rw, logic [7:0] dev, logic [7:0] rg, logic [7:0] wd,
                                int nk, int al, bit na, logic [1:0] err, logic [7:0] rd,
                                int ncmd, int nstop, int actv,
                                logic [3:0][4:0] bits, logic [3:0][7:0] din);
      vec_t v;
      v.rw = rw; v.dev = dev; v.rg = rg; v.wdata = wd;
      v.nack_dev = nk; v.al_idx = al; v.no_ack = na;
      v.exp_err = err; v.exp_rdata = rd;
      v.exp_ncmd = ncmd; v.exp_nstop = nstop; v.exp_active = actv;
      v.exp_bits = bits; v.exp_din = din;
      return v;
   endfunction

   task automatic do_txn(input vec_t v, input string nm);
      int n, nstop, ncmp;
      logic [1:0] got_err;
      logic [7:0] got_rdata;
      @(posedge clk);
      #1;
      clear_model();
      nack_dev = v.nack_dev;
      al_idx   = v.al_idx;
      no_ack   = v.no_ack;
      @(negedge clk);
      n = 0;
      while (!req_ready && n < 100) begin @(negedge clk); n++; end
      check({nm, " ready_before"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_rw = v.rw; req_dev = v.dev; req_reg = v.rg; req_wdata = v.wdata;
      @(negedge clk);
      req_valid = 1'b0;
      check({nm, " first_cmd_latency"}, 32'(i2c_start), 32'd1);
      check({nm, " ready_dropped"}, 32'(req_ready), 32'd0);
      n = 0;
      while (!rsp_valid && n < 3000) begin @(negedge clk); n++; end
      check({nm, " rsp_seen"}, 32'(rsp_valid), 32'd1);
      got_err   = rsp_err;
      got_rdata = rsp_rdata;
      check({nm, " err"}, 32'(got_err), 32'(v.exp_err));
      check({nm, " rdata"}, 32'(got_rdata), 32'(v.exp_rdata));
      @(negedge clk);
      check({nm, " rsp_pulse_one_cycle"}, 32'(rsp_valid), 32'd0);
      check({nm, " ready_returns"}, 32'(req_ready), 32'd1);
      check({nm, " err_held"}, 32'(rsp_err), 32'(v.exp_err));
      check({nm, " ncmd"}, 32'(cmd_log.size()), 32'(v.exp_ncmd));
      nstop = 0;
      foreach (cmd_log[i]) if (cmd_log[i].bits[3]) nstop++;
      check({nm, " nstop"}, 32'(nstop), 32'(v.exp_nstop));
      ncmp = (cmd_log.size() < 4) ? cmd_log.size() : 4;
      for (int k = 0; k < ncmp; k++) begin
         check($sformatf("%s cmd%0d_bits", nm, k), 32'(cmd_log[k].bits), 32'(v.exp_bits[3-k]));
         if (v.exp_bits[3-k][1])
            check($sformatf("%s cmd%0d_din", nm, k), 32'(cmd_log[k].din), 32'(v.exp_din[3-k]));
      end
      check({nm, " cmd_stable"}, 32'(stab_err), 32'd0);
      if (cmd_log.size() > 1) check({nm, " min_gap_ok"}, 32'(min_gap >= GAP_CYC), 32'd1);
      if (v.exp_active != 0) check({nm, " active_cycles"}, 32'(last_active), 32'(v.exp_active));
      if (v.al_idx >= 0) check({nm, " al_drop_same_cycle"}, 32'(al_drop_bad), 32'd0);
   endtask

   vec_t vt[8];
   vec_t post_wr;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic saw_rsp;
      vt[0] = mkv(0, 8'h98, 8'h41, 8'h10, 0, -1, 0, 2'd0, 8'h00, 3, 1, 0,
                  {B_DEV, B_REG, B_DATA, 5'b0}, {8'h98, 8'h41, 8'h10, 8'h00});
      vt[1] = mkv(1, 8'h98, 8'h96, 8'h00, 0, -1, 0, 2'd0, 8'hA5, 4, 1, 0,
                  {B_DEV, B_REG, B_DEV, B_RD}, {8'h98, 8'h96, 8'h99, 8'h00});
      vt[2] = mkv(0, 8'h99, 8'h00, 8'hFF, 0, -1, 0, 2'd0, 8'h00, 3, 1, 0,
                  {B_DEV, B_REG, B_DATA, 5'b0}, {8'h98, 8'h00, 8'hFF, 8'h00});
      vt[3] = mkv(1, 8'h98, 8'h41, 8'h00, 2, -1, 0, 2'd0, 8'hA5, 8, 3, 0,
                  {B_DEV, B_STOP, B_DEV, B_STOP}, {8'h98, 8'h00, 8'h98, 8'h00});
      vt[4] = mkv(0, 8'h98, 8'h41, 8'h10, 99, -1, 0, 2'd1, 8'h00, 6, 3, 0,
                  {B_DEV, B_STOP, B_DEV, B_STOP}, {8'h98, 8'h00, 8'h98, 8'h00});
      vt[5] = mkv(0, 8'h98, 8'h41, 8'h10, 0, 1, 0, 2'd2, 8'h00, 2, 0, 0,
                  {B_DEV, B_REG, 5'b0, 5'b0}, {8'h98, 8'h41, 8'h00, 8'h00});
      vt[6] = mkv(1, 8'h98, 8'h96, 8'h00, 0, -1, 1, 2'd3, 8'h00, 1, 0, TO_CYC,
                  {B_DEV, 5'b0, 5'b0, 5'b0}, {8'h98, 8'h00, 8'h00, 8'h00});
      vt[7] = mkv(1, 8'h98, 8'h96, 8'h00, 99, -1, 0, 2'd1, 8'h00, 6, 3, 0,
                  {B_DEV, B_STOP, B_DEV, B_STOP}, {8'h98, 8'h00, 8'h98, 8'h00});

      // Reset with req_valid asserted: must be ignored
      reset = 1'b1; req_valid = 1'b1; req_rw = 1'b0;
      req_dev = 8'h98; req_reg = 8'h41; req_wdata = 8'h10;
      clear_model();
      repeat (3) @(negedge clk);
      check("reset req_ready", 32'(req_ready), 32'd0);
      check("reset rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset rsp_err", 32'(rsp_err), 32'd0);
      check("reset rsp_rdata", 32'(rsp_rdata), 32'd0);
      check("reset cmd_bits", 32'({i2c_start, i2c_stop, i2c_read, i2c_write, i2c_ack_out}), 32'd0);
      check("reset din", 32'(i2c_din), 32'd0);
      reset = 1'b0; req_valid = 1'b0;
      @(negedge clk);
      check("post_reset ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      check("reset req_valid ignored", 32'(i2c_start), 32'd0);

      for (int i = 0; i < 8; i++) do_txn(vt[i], $sformatf("vec%0d", i));

      // Reset during the RDEV step of a read
      @(posedge clk);
      #1;
      clear_model();
      nack_dev = 0; al_idx = -1; no_ack = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_rw = 1'b1; req_dev = 8'h98; req_reg = 8'h96;
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      saw_rsp = 1'b0;
      while (cmd_log.size() < 3 && n < 500) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("mid_reset reached_rdev", 32'(cmd_log.size()), 32'd3);
      check("mid_reset rdev_din", 32'(i2c_din), 32'h99);
      reset = 1'b1;
      @(negedge clk);
      saw_rsp |= rsp_valid;
      check("mid_reset cmd_bits", 32'({i2c_start, i2c_stop, i2c_read, i2c_write, i2c_ack_out}), 32'd0);
      check("mid_reset din", 32'(i2c_din), 32'd0);
      check("mid_reset ready", 32'(req_ready), 32'd0);
      check("mid_reset rsp_err", 32'(rsp_err), 32'd0);
      reset = 1'b0;
      repeat (3) begin
         @(negedge clk);
         saw_rsp |= rsp_valid;
      end
      check("mid_reset no_rsp", 32'(saw_rsp), 32'd0);
      check("mid_reset ready_back", 32'(req_ready), 32'd1);
      post_wr = vt[0];
      do_txn(post_wr, "post_reset_write");

      // req_valid held across rsp_valid: next request accepted once ready
      @(negedge clk);
      req_valid = 1'b1; req_rw = 1'b0; req_dev = 8'h98; req_reg = 8'h41; req_wdata = 8'h10;
      nack_dev = 0; al_idx = -1; no_ack = 1'b0;
      n = 0;
      while (!rsp_valid && n < 500) begin @(negedge clk); n++; end
      check("held_valid first_rsp", 32'(rsp_valid), 32'd1);
      @(negedge clk);
      check("held_valid ready_after_rsp", 32'(req_ready), 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
      check("held_valid second_accept", 32'(i2c_start), 32'd1);
      n = 0;
      while (!rsp_valid && n < 500) begin @(negedge clk); n++; end
      check("held_valid second_rsp_err", 32'({rsp_valid, rsp_err}), 32'({1'b1, 2'd0}));
      repeat (2) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
